// File: rtl/maze_pkg.sv
// Shared constants and types for the maze engine movement scheduler.
// Actor indices, FSM state encoding and a one-hot to index helper.
package maze_pkg;

  localparam int N_ACT      = 3;
  localparam int ACT_PAC    = 0;
  localparam int ACT_CLYDE  = 1;
  localparam int ACT_BLINKY = 2;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } sched_state_e;

  function automatic logic [1:0] onehot_idx(
    input logic [N_ACT-1:0] oh
  );
    logic [1:0] idx;
    idx = 2'd0;
    unique case (1'b1)
      oh[ACT_CLYDE]:  idx = 2'd1;
      oh[ACT_BLINKY]: idx = 2'd2;
      default:        idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin pick: search starts just above the last winner.
// Purely combinational; returns a one-hot grant or zero.
module rr_arbiter3
  import maze_pkg::*;
(
  input  logic [N_ACT-1:0] req,
  input  logic [1:0]       ptr,
  output logic [N_ACT-1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (ptr)
      2'd0: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      2'd1: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/move_scheduler.sv
// Actor move scheduler: base-tick divider, per-actor period counters,
// pending/overrun tracking and a round-robin grant FSM.
module move_scheduler
  import maze_pkg::*;
#(
  parameter int BASE_DIV = 33554432,
  parameter int CNT_W    = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             frightened,
  input  logic [3:0]       period_pac,
  input  logic [3:0]       period_ghost,
  input  logic             move_ack,
  output logic [N_ACT-1:0] grant,
  output logic [N_ACT-1:0] pending,
  output logic             base_tick,
  output logic             mouth_open,
  output logic             overrun
);

  sched_state_e state_q, state_d;

  logic [CNT_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [3:0]       pac_cnt_q, pac_cnt_d;
  logic [4:0]       cly_cnt_q, cly_cnt_d;
  logic [4:0]       bli_cnt_q, bli_cnt_d;
  logic [N_ACT-1:0] pend_q, pend_d;
  logic [N_ACT-1:0] grant_q, grant_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             mouth_q, mouth_d;
  logic             ovr_q, ovr_d;

  logic [N_ACT-1:0] set_v, clr_v, pick;
  logic [3:0]       pac_per;
  logic [4:0]       gh_base, gh_per;
  logic             pac_exp, cly_exp, bli_exp;

  rr_arbiter3 u_arb (
    .req (pend_q),
    .ptr (ptr_q),
    .gnt (pick)
  );

  assign pac_per = (period_pac == 4'd0) ? 4'd1 : period_pac;
  assign gh_base = (period_ghost == 4'd0) ? 5'd1 : {1'b0, period_ghost};
  assign gh_per  = frightened ? (gh_base << 1) : gh_base;

  assign pac_exp = ({1'b0, pac_cnt_q} + 5'd1) >= {1'b0, pac_per};
  assign cly_exp = ({1'b0, cly_cnt_q} + 6'd1) >= {1'b0, gh_per};
  assign bli_exp = ({1'b0, bli_cnt_q} + 6'd1) >= {1'b0, gh_per};

  always_comb begin
    div_d     = div_q;
    tick_d    = 1'b0;
    pac_cnt_d = pac_cnt_q;
    cly_cnt_d = cly_cnt_q;
    bli_cnt_d = bli_cnt_q;
    set_v     = '0;
    if (en) begin
      if (div_q == CNT_W'(BASE_DIV - 1)) begin
        div_d  = '0;
        tick_d = 1'b1;
      end else begin
        div_d = div_q + CNT_W'(1);
      end
    end
    if (tick_q) begin
      pac_cnt_d = pac_exp ? 4'd0 : pac_cnt_q + 4'd1;
      cly_cnt_d = cly_exp ? 5'd0 : cly_cnt_q + 5'd1;
      bli_cnt_d = bli_exp ? 5'd0 : bli_cnt_q + 5'd1;
      set_v     = {bli_exp, cly_exp, pac_exp};
    end
  end

  // A set landing on a bit being acked in the same cycle is not an overrun.
  always_comb begin
    pend_d = (pend_q & ~clr_v) | set_v;
    ovr_d  = ovr_q | (|(set_v & pend_q & ~clr_v));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (en && (|pend_q)) state_d = S_GRANT;
      S_GRANT: if (move_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    clr_v   = '0;
    ptr_d   = ptr_q;
    mouth_d = mouth_q;
    unique case (state_q)
      S_IDLE: begin
        if (en && (|pend_q)) grant_d = pick;
      end
      S_GRANT: begin
        if (move_ack) begin
          clr_v   = grant_q;
          ptr_d   = onehot_idx(grant_q);
          grant_d = '0;
          mouth_d = mouth_q ^ grant_q[ACT_PAC];
        end
      end
      default: grant_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      tick_q    <= 1'b0;
      pac_cnt_q <= '0;
      cly_cnt_q <= '0;
      bli_cnt_q <= '0;
      pend_q    <= '0;
      grant_q   <= '0;
      ptr_q     <= 2'd2;
      mouth_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      pac_cnt_q <= pac_cnt_d;
      cly_cnt_q <= cly_cnt_d;
      bli_cnt_q <= bli_cnt_d;
      pend_q    <= pend_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      mouth_q   <= mouth_d;
      ovr_q     <= ovr_d;
    end
  end

  assign grant      = grant_q;
  assign pending    = pend_q;
  assign base_tick  = tick_q;
  assign mouth_open = mouth_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with BASE_DIV=4.
// Edge numbering below counts posedges after the reset edge.
module tb_move_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       frightened;
  logic [3:0] period_pac;
  logic [3:0] period_ghost;
  logic       move_ack;
  logic [2:0] grant;
  logic [2:0] pending;
  logic       base_tick;
  logic       mouth_open;
  logic       overrun;

  int n_chk  = 0;
  int n_fail = 0;

  move_scheduler #(
    .BASE_DIV (4),
    .CNT_W    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .frightened   (frightened),
    .period_pac   (period_pac),
    .period_ghost (period_ghost),
    .move_ack     (move_ack),
    .grant        (grant),
    .pending      (pending),
    .base_tick    (base_tick),
    .mouth_open   (mouth_open),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    en           = 1'b0;
    frightened   = 1'b0;
    period_pac   = 4'd0;
    period_ghost = 4'd0;
    move_ack     = 1'b0;

    // reset and stray ack
    step(2);
    rst_n = 1'b1;
    step(1);
    check("rst_grant", 8'(grant), 8'h0);
    check("rst_pending", 8'(pending), 8'h0);
    check("rst_tick", 8'(base_tick), 8'h0);
    check("rst_mouth", 8'(mouth_open), 8'h0);
    check("rst_overrun", 8'(overrun), 8'h0);
    move_ack = 1'b1;
    step(1);
    move_ack = 1'b0;
    step(1);
    check("idle_ack_grant", 8'(grant), 8'h0);
    check("idle_ack_mouth", 8'(mouth_open), 8'h0);
    step(8);
    check("paused_tick", 8'(base_tick), 8'h0);
    check("paused_pending", 8'(pending), 8'h0);

    // single actor
    en           = 1'b1;
    period_pac   = 4'd2;
    period_ghost = 4'd15;
    do_reset();
    step(3);
    check("s_tick_e3", 8'(base_tick), 8'h0);
    step(1);
    check("s_tick_e4", 8'(base_tick), 8'h1);
    step(5);
    check("s_pend_e9", 8'(pending), 8'h1);
    check("s_grant_e9", 8'(grant), 8'h0);
    step(1);
    check("s_grant_e10", 8'(grant), 8'h1);
    step(2);
    move_ack = 1'b1;
    step(1);
    move_ack = 1'b0;
    check("s_ack1_grant", 8'(grant), 8'h0);
    check("s_ack1_pend", 8'(pending), 8'h0);
    check("s_ack1_mouth", 8'(mouth_open), 8'h1);
    step(5);
    check("s_grant_e18", 8'(grant), 8'h1);
    step(2);
    move_ack = 1'b1;
    step(1);
    move_ack = 1'b0;
    check("s_ack2_mouth", 8'(mouth_open), 8'h0);
    check("s_ack2_grant", 8'(grant), 8'h0);

    // simultaneous expiry
    period_pac   = 4'd1;
    period_ghost = 4'd1;
    do_reset();
    step(5);
    check("m_pend_e5", 8'(pending), 8'h7);
    check("m_grant_e5", 8'(grant), 8'h0);
    step(1);
    check("m_grant_pac", 8'(grant), 8'h1);
    move_ack = 1'b1;
    step(1);
    move_ack = 1'b0;
    check("m_pend_e7", 8'(pending), 8'h6);
    check("m_mouth_e7", 8'(mouth_open), 8'h1);
    step(1);
    check("m_grant_clyde", 8'(grant), 8'h2);
    move_ack = 1'b1;
    step(1);
    move_ack = 1'b0;
    check("m_pend_e9", 8'(pending), 8'h7);
    check("m_overrun_e9", 8'(overrun), 8'h1);
    step(1);
    check("m_grant_blinky", 8'(grant), 8'h4);
    move_ack = 1'b1;
    step(1);
    move_ack = 1'b0;
    check("m_pend_e11", 8'(pending), 8'h3);
    step(1);
    check("m_grant_wrap", 8'(grant), 8'h1);

    // overrun with ack withheld
    period_pac   = 4'd1;
    period_ghost = 4'd15;
    do_reset();
    step(5);
    check("o_pend_e5", 8'(pending), 8'h1);
    step(1);
    check("o_grant_e6", 8'(grant), 8'h1);
    step(2);
    check("o_ovr_e8", 8'(overrun), 8'h0);
    step(1);
    check("o_ovr_e9", 8'(overrun), 8'h1);
    step(9);
    check("o_grant_e18", 8'(grant), 8'h1);
    check("o_pend_e18", 8'(pending), 8'h1);
    move_ack = 1'b1;
    step(1);
    move_ack = 1'b0;
    check("o_grant_e19", 8'(grant), 8'h0);
    check("o_pend_e19", 8'(pending), 8'h0);
    check("o_ovr_sticky", 8'(overrun), 8'h1);

    // frightened ghosts and pause mid-grant
    period_pac   = 4'd15;
    period_ghost = 4'd2;
    frightened   = 1'b1;
    do_reset();
    step(16);
    check("f_pend_e16", 8'(pending), 8'h0);
    step(1);
    check("f_pend_e17", 8'(pending), 8'h6);
    step(1);
    check("f_grant_e18", 8'(grant), 8'h2);
    en = 1'b0;
    step(6);
    check("f_hold_grant", 8'(grant), 8'h2);
    check("f_hold_tick", 8'(base_tick), 8'h0);
    move_ack = 1'b1;
    step(1);
    move_ack = 1'b0;
    check("f_ack_grant", 8'(grant), 8'h0);
    check("f_ack_pend", 8'(pending), 8'h4);
    step(5);
    check("f_paused_grant", 8'(grant), 8'h0);
    check("f_paused_pend", 8'(pending), 8'h4);
    check("f_paused_tick", 8'(base_tick), 8'h0);
    en = 1'b1;
    step(1);
    check("f_resume_grant", 8'(grant), 8'h4);
    check("f_resume_tick0", 8'(base_tick), 8'h0);
    step(1);
    check("f_resume_tick1", 8'(base_tick), 8'h1);

    // reset during grant
    period_pac   = 4'd1;
    period_ghost = 4'd15;
    frightened   = 1'b0;
    do_reset();
    step(6);
    check("r_grant_e6", 8'(grant), 8'h1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    en    = 1'b0;
    check("r_grant_cleared", 8'(grant), 8'h0);
    check("r_pend_cleared", 8'(pending), 8'h0);
    check("r_mouth_cleared", 8'(mouth_open), 8'h0);
    move_ack = 1'b1;
    step(1);
    move_ack = 1'b0;
    step(1);
    check("r_late_ack_grant", 8'(grant), 8'h0);
    check("r_late_ack_mouth", 8'(mouth_open), 8'h0);
    check("r_late_ack_pend", 8'(pending), 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
# move_scheduler

Sequences actor movement for the maze engine, replacing the bare free-running display counter with a scheduled system. A base-tick divider drives one period counter per actor: Pacman, Clyde and Blinky. Each counter raises a move request when it expires. A round-robin arbiter grants the shared move/collision datapath to one actor at a time. The block also owns the Pacman mouth-animation phase, which toggles on each completed Pacman move.

## Interface

Parameters:
- `BASE_DIV`, default 33554432 (2^25): clk cycles per base tick. Use 4 in simulation. Must be ≥ 2.
- `CNT_W`, default 26: divider width. Must satisfy 2^CNT_W ≥ `BASE_DIV`.

Ports (sync reset: one clock, `clk`; `rst_n` is synchronous and active-low):
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: synchronous active-low reset.
- `en`, in, 1: game running. Low means paused.
- `frightened`, in, 1: ghost slow mode. Doubles the ghost periods.
- `period_pac`, in, 4: Pacman period in base ticks. 0 is treated as 1.
- `period_ghost`, in, 4: Clyde and Blinky period in base ticks. 0 is treated as 1.
- `move_ack`, in, 1: the move datapath has finished the granted move.
- `grant`, out, 3: one-hot grant. Bit 0 = Pacman, bit 1 = Clyde, bit 2 = Blinky.
- `pending`, out, 3: outstanding request bits, same bit order as `grant`.
- `base_tick`, out, 1: one-cycle pulse at the divider terminal count.
- `mouth_open`, out, 1: Pacman sprite phase.
- `overrun`, out, 1: sticky flag. Set when an actor expires while its pending bit is already set.

## Operation

Reset:
- While `rst_n` is low at a clk edge, all state clears.
- Divider, actor counters, `pending`, `grant`, `base_tick`, `overrun` and `mouth_open` all go to 0.
- Round-robin pointer resets to 2, so Pacman wins first.
- FSM resets to IDLE.
- Reset mid-grant drops the grant immediately. Any `move_ack` arriving afterwards is ignored.

Divider:
- Counts 0..`BASE_DIV`-1 while `en`=1 and holds while `en`=0.
- `base_tick` is registered and asserts in the cycle after the count wraps to 0.

Actor counters (4-bit Pacman, 5-bit ghosts):
- Each increments on `base_tick`.
- The effective period is `max(period,1)`. Ghosts use `max(period_ghost,1)<<1` when `frightened`=1.
- A counter expires when count+1 ≥ effective period. On expiry the counter returns to 0 and the actor's pending bit is set.
- A period change takes effect at the next tick comparison. There is no reset of in-flight counts.

Pending and overrun:
- If the pending bit is already 1 at expiry, `overrun` is set. There is no queueing.
- If set and clear hit the same bit in the same cycle, set wins. This is not an overrun.

FSM (one-hot or binary; IDLE, GRANT):
- IDLE: if `en`=1 and any `pending` bit is set, select the first set bit searching from pointer+1 upward, modulo 3. Register `grant` to that one-hot value and go to GRANT.
- GRANT: `grant` is held stable. On `move_ack`:
  - clear that pending bit;
  - pointer ← granted index;
  - `grant` ← 0;
  - if the granted actor is Pacman, toggle `mouth_open`;
  - return to IDLE.
- In GRANT, `en` falling does not withdraw the grant; the block still waits for ack.
- `move_ack` while in IDLE is ignored.

## Timing

- A pending bit sets in the cycle after `base_tick`.
- `grant` asserts 1 cycle after the pending bit is visible in IDLE.
- `grant` deasserts and the pending bit clears in the cycle after `move_ack` is sampled.
- Minimum re-grant spacing is 1 IDLE cycle, so back-to-back grants are ≥ 2 cycles apart.
- At most one `grant` bit is ever high.
- Worst-case service latency for a pending actor is 2 grant completions.

## Structure

- A shared package, `maze_pkg`, holds:
  - actor index constants `ACT_PAC`=0, `ACT_CLYDE`=1, `ACT_BLINKY`=2, and `N_ACT`=3;
  - the FSM state typedef.
- One natural sub-module, `rr_arbiter3`: a combinational round-robin pick from `pending` plus the pointer, returning a one-hot result.
- The divider and actor counters stay inline.

## Test plan

1. **Reset / ack.** Reset with all inputs idle → every output is 0. Pulse `move_ack` in IDLE → no change.
2. **Single actor.** `BASE_DIV`=4, `period_pac`=2, ghost period 15. Ack 3 cycles after each grant → `grant`=001 every 8 cycles; `mouth_open` toggles per ack.
3. **Simultaneous expiry.** `period_pac`=`period_ghost`=1. All three pend on the same tick. Ack 1 cycle after each grant → grants issue 001, 010, 100 in order; the pointer then rotates fairness.
4. **Overrun.** `period_pac`=1, `move_ack` withheld for 12 cycles → `overrun`=1 after the second expiry. `grant` stays 001 and `pending[0]` remains 1.
5. **Frightened / pause.** `period_ghost`=2, `frightened`=1 → ghost pend every 16 cycles (4 ticks). Drop `en` mid-grant → `grant` held until ack; no new grant and the divider is frozen until `en`=1.
6. **Reset during GRANT.** Assert `rst_n`=0 for 1 cycle during GRANT → `grant`=000 and `pending`=000 next cycle. A later `move_ack` is ignored.
